led_frame_driver: RTL and testbench

Downstream consumer of the board memory. It walks all 64 cells of the 8x8 board, fetches each cell's 8-bit colour byte through the memory's registered read port, and serialises it as a 24-bit GRB WS2812B word on a single LED data line. It pulses `write_board_state` once per pixel and `writing_board_done` once per frame, so the memory's pixel counter and board-state commit stay in lockstep with the physical refresh.

---
 rtl/led_frame_driver.sv | 139 +++++++++++++
 tb/tb_led_frame_driver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_driver.sv
// WS2812B frame driver: walks the 8x8 board, fetches each colour byte, shifts out GRB words.
// LED_DRIVER_SERPENTINE_EN selects serpentine panel addressing (odd rows reversed).
module led_frame_driver #(
    parameter int BIT_CYCLES   = 15,
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 8,
    parameter int RESET_CYCLES = 600,
    parameter int GREEN_EN     = 1,
    parameter int RED_EN       = 0,
    parameter int BLUE_EN      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pixel_data,
    output logic [5:0] read_address,
    output logic       write_board_state,
    output logic       writing_board_done,
    output logic       led_out,
    output logic       busy
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [LW-1:0] LAT_PRE  = LW'(RESET_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [4:0]    bit_idx;
    logic [23:0]   word;
    logic [5:0]    pix;
    logic          fetch_2nd;
    logic [LW-1:0] lcnt;
    logic [23:0]   new_word;

    function automatic logic [5:0] map_pix(input logic [5:0] p);
`ifdef LED_DRIVER_SERPENTINE_EN
        return p[3] ? {p[5:3], ~p[2:0]} : p;
`else
        return p;
`endif
    endfunction

    // Level of the line at clock c of a bit whose value is b.
    function automatic logic high_at(input logic b, input int c);
        return b ? (c < T1H_CYCLES) : (c < T0H_CYCLES);
    endfunction

    assign new_word = {(GREEN_EN != 0) ? pixel_data : 8'h00,
                       (RED_EN   != 0) ? pixel_data : 8'h00,
                       (BLUE_EN  != 0) ? pixel_data : 8'h00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cyc                <= '0;
            bit_idx            <= '0;
            word               <= '0;
            pix                <= '0;
            fetch_2nd          <= 1'b0;
            lcnt               <= '0;
            read_address       <= '0;
            write_board_state  <= 1'b0;
            writing_board_done <= 1'b0;
            led_out            <= 1'b0;
            busy               <= 1'b0;
        end else begin
            writing_board_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    led_out <= 1'b0;
                    busy    <= 1'b0;
                    if (start) begin
                        state        <= FETCH;
                        pix          <= '0;
                        read_address <= map_pix(6'd0);
                        fetch_2nd    <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!fetch_2nd) begin
                        fetch_2nd <= 1'b1;
                    end else begin
                        fetch_2nd         <= 1'b0;
                        word              <= new_word;
                        bit_idx           <= 5'd23;
                        cyc               <= '0;
                        led_out           <= high_at(new_word[23], 0);
                        write_board_state <= 1'b1;
                        state             <= SEND;
                    end
                end
                SEND: begin
                    if (cyc != CYC_LAST) begin
                        cyc     <= cyc + CW'(1);
                        led_out <= high_at(word[bit_idx], int'(cyc) + 1);
                    end else begin
                        cyc <= '0;
                        if (bit_idx != 5'd0) begin
                            bit_idx <= bit_idx - 5'd1;
                            led_out <= high_at(word[bit_idx - 5'd1], 0);
                        end else begin
                            led_out           <= 1'b0;
                            write_board_state <= 1'b0;
                            if (pix == 6'd63) begin
                                state              <= LATCH;
                                lcnt               <= '0;
                                writing_board_done <= (RESET_CYCLES == 1);
                            end else begin
                                pix          <= pix + 6'd1;
                                read_address <= map_pix(pix + 6'd1);
                                fetch_2nd    <= 1'b0;
                                state        <= FETCH;
                            end
                        end
                    end
                end
                LATCH: begin
                    led_out <= 1'b0;
                    if (lcnt == LAT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        lcnt  <= '0;
                    end else begin
                        lcnt               <= lcnt + LW'(1);
                        writing_board_done <= (lcnt == LAT_PRE);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_driver.sv
// Self-checking bench for led_frame_driver: cycle model plus an independent
// WS2812B decoder, handshake counters and hand-computed literal checks.
module tb_led_frame_driver;

    localparam int PIX   = 362;
    localparam int FRAME = 23768;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pixel_data;
    logic [5:0] read_address;
    logic       write_board_state;
    logic       writing_board_done;
    logic       led_out;
    logic       busy;

    always #5 clk = ~clk;

    led_frame_driver dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .pixel_data         (pixel_data),
        .read_address       (read_address),
        .write_board_state  (write_board_state),
        .writing_board_done (writing_board_done),
        .led_out            (led_out),
        .busy               (busy)
    );

    // Board memory: one registered stage behind read_address.
    logic [7:0] mem [64];
    always @(posedge clk) pixel_data <= mem[read_address];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Board cell shown by physical pixel i (row/column view of the wiring).
    function automatic int serp(input int i);
`ifdef LED_DRIVER_SERPENTINE_EN
        if ((i / 8) % 2 == 1) return (i / 8) * 8 + 7 - (i % 8);
`endif
        return i;
    endfunction

    // Model: frame position k counted from the accepted start edge.
    bit mbusy = 1'b0;
    int mk = 0;
    int maddr = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mbusy = 1'b0;
            maddr = 0;
        end else if (mbusy) begin
            if (mk == FRAME - 1) begin
                mbusy = 1'b0;
                maddr = serp(63);
            end else begin
                mk++;
            end
        end else if (start) begin
            mbusy = 1'b1;
            mk = 0;
        end
    end

    // Returns {busy, done, wbs, led, addr[5:0]} for the current cycle.
    function automatic logic [9:0] expect_now();
        logic l = 1'b0, w = 1'b0, d = 1'b0, b = 1'b0;
        logic [5:0] a;
        logic [7:0] g;
        int pix, r, bi, c;
        a = 6'(maddr);
        if (mbusy) begin
            b = 1'b1;
            pix = mk / PIX;
            r = mk % PIX;
            if (pix < 64) begin
                a = 6'(serp(pix));
                if (r >= 2) begin
                    bi = (r - 2) / 15;
                    c = (r - 2) % 15;
                    g = mem[serp(pix)];
                    w = 1'b1;
                    l = (bi < 8 && g[7 - bi]) ? (c < 8) : (c < 4);
                end
            end else begin
                a = 6'(serp(63));
                d = (mk == FRAME - 1);
            end
        end
        return {b, d, w, l, a};
    endfunction

    bit          chk_en = 1'b0;
    int          falls, dones, done_k, hi, nbits;
    logic        prev_led = 1'b0, prev_wbs = 1'b0;
    logic [23:0] acc;
    logic [23:0] words[$];
    int          addrs[$];
    logic        trace[64];
    logic [9:0]  e;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e = expect_now();
            check("busy", busy, e[9]);
            check("done", writing_board_done, e[8]);
            check("wbs", write_board_state, e[7]);
            check("led", led_out, e[6]);
            check("addr", read_address, e[5:0]);
            if (mbusy && mk < 64) trace[mk] = led_out;
            if (led_out && !prev_led) hi = 1;
            else if (led_out) hi++;
            else if (prev_led) begin
                acc = {acc[22:0], hi > 6};
                nbits++;
                if (nbits == 24) begin
                    words.push_back(acc);
                    nbits = 0;
                end
            end
            if (write_board_state && !prev_wbs) addrs.push_back(int'(read_address));
            if (!write_board_state && prev_wbs) falls++;
            if (writing_board_done) begin
                dones++;
                done_k = mk;
            end
            prev_led = led_out;
            prev_wbs = write_board_state;
        end
    end

    task automatic clear_stats();
        falls = 0;
        dones = 0;
        done_k = -1;
        hi = 0;
        nbits = 0;
        words.delete();
        addrs.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_k(input int t);
        int n = 0;
        while (!(mbusy && mk == t) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("wait_bound", 32'(mbusy && mk == t), 1);
    endtask

    task automatic finish_frame(input bit lit);
        int n = 0;
        logic [23:0] ew;
        while (mbusy && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("frame_bound", 32'(mbusy), 0);
        repeat (2) @(negedge clk);
        check("wbs_falls", falls, 64);
        check("done_pulses", dones, 1);
        check("done_cycle", done_k + 1, 23768);
        check("word_count", words.size(), 64);
        check("addr_count", addrs.size(), 64);
        for (int p = 0; p < 64; p++) begin
            ew = lit ? 24'hF00000 : {mem[serp(p)], 16'h0000};
            if (p < words.size()) check($sformatf("word%0d", p), words[p], ew);
            if (p < addrs.size()) check($sformatf("seq%0d", p), addrs[p], serp(p));
        end
    endtask

    task automatic bit_runs();
        int i = 2;
        int h1 = 0, l1 = 0, h2 = 0, l2 = 0;
        while (i < 64 && trace[i] === 1'b1) begin h1++; i++; end
        while (i < 64 && trace[i] === 1'b0) begin l1++; i++; end
        while (i < 64 && trace[i] === 1'b1) begin h2++; i++; end
        while (i < 64 && trace[i] === 1'b0) begin l2++; i++; end
        check("bit1_high", h1, 8);
        check("bit1_low", l1, 7);
        check("bit2_high", h2, 4);
        check("bit2_low", l2, 11);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_led", led_out, 0);
        check("rst_addr", read_address, 0);
        check("rst_wbs", write_board_state, 0);
        check("rst_done", writing_board_done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_busy", busy, 0);

        // Frame A: all cells F0, stray start at pixel 20.
        for (int i = 0; i < 64; i++) mem[i] = 8'hF0;
        clear_stats();
        pulse_start();
        check("start_busy", busy, 1);
        check("start_addr", read_address, 0);
        wait_k(20 * PIX + 50);
        pulse_start();
        finish_frame(1'b1);

        // Frame B: varied data, cell 0 = 80 for bit timing.
        for (int i = 0; i < 64; i++) mem[i] = 8'h80 ^ 8'(i * 29);
        clear_stats();
        pulse_start();
        finish_frame(1'b0);
        bit_runs();

        // Abort during SEND of pixel 30, then restart.
        clear_stats();
        pulse_start();
        wait_k(30 * PIX + 100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_led", led_out, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", read_address, 0);
        repeat (20) @(negedge clk);
        check("abort_done", dones, 0);
        clear_stats();
        pulse_start();
        check("restart_busy", busy, 1);
        check("restart_addr", read_address, 0);
        repeat (1000) @(negedge clk);
        check("restart_first", addrs.size() > 0 ? addrs[0] : -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
